// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - key codes, opcodes, state encodings and helpers for the keypad calculator
//
// Purpose: definitions shared by keypad_scan and calc_entry_ctrl.
//   KEY_* : 4-bit key event codes (digits are their own value)
//   OP_*  : arithmetic unit opcodes
//   entry_state_t / scan_state_t : controller and scanner state encodings
//   keymap()   : (row, col) -> key code
//   op_of_key(): operator key -> opcode
//   bcd_ndig() : count of significant BCD digits (0 for zero)
package calc_pkg;

   localparam logic [3:0] KEY_0   = 4'd0;
   localparam logic [3:0] KEY_1   = 4'd1;
   localparam logic [3:0] KEY_2   = 4'd2;
   localparam logic [3:0] KEY_3   = 4'd3;
   localparam logic [3:0] KEY_4   = 4'd4;
   localparam logic [3:0] KEY_5   = 4'd5;
   localparam logic [3:0] KEY_6   = 4'd6;
   localparam logic [3:0] KEY_7   = 4'd7;
   localparam logic [3:0] KEY_8   = 4'd8;
   localparam logic [3:0] KEY_9   = 4'd9;
   localparam logic [3:0] KEY_ADD = 4'd10;
   localparam logic [3:0] KEY_SUB = 4'd11;
   localparam logic [3:0] KEY_MUL = 4'd12;
   localparam logic [3:0] KEY_DIV = 4'd13;
   localparam logic [3:0] KEY_EQ  = 4'd14;
   localparam logic [3:0] KEY_CLR = 4'd15;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef enum logic [2:0] {ENTER_A, OP_WAIT, ENTER_B, CALC, SHOW} entry_state_t;
   typedef enum logic [1:0] {SCAN, PRESS_DB, EMIT, RELEASE_DB} scan_state_t;

   function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] k;
      case ({row, col})
         4'h0:    k = KEY_1;
         4'h1:    k = KEY_2;
         4'h2:    k = KEY_3;
         4'h3:    k = KEY_ADD;
         4'h4:    k = KEY_4;
         4'h5:    k = KEY_5;
         4'h6:    k = KEY_6;
         4'h7:    k = KEY_SUB;
         4'h8:    k = KEY_7;
         4'h9:    k = KEY_8;
         4'hA:    k = KEY_9;
         4'hB:    k = KEY_MUL;
         4'hC:    k = KEY_CLR;
         4'hD:    k = KEY_0;
         4'hE:    k = KEY_EQ;
         default: k = KEY_DIV;
      endcase
      return k;
   endfunction

   // Operator keys are contiguous and ordered like the opcodes.
   function automatic logic [1:0] op_of_key(input logic [3:0] k);
      logic [3:0] d;
      d = k - KEY_ADD;
      return d[1:0];
   endfunction

   function automatic logic [3:0] bcd_ndig(input logic [31:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++)
         if (v[4*i +: 4] != 4'd0) n = 4'(i + 1);
      return n;
   endfunction

endpackage

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 keypad row scanner with press/release debounce
//
// Purpose: drives one keypad row low at a time, locks onto a single pressed
// column, debounces press and release, and emits one key event per press.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   kp_col_n[3:0]      : keypad columns, active-low (asynchronous to clk)
//   kp_row_n[3:0]      : row drive, one-hot low
//   key_valid          : one-cycle key event strobe
//   key_code[3:0]      : key code, valid with key_valid
module keypad_scan
   import calc_pkg::*;
#(
   parameter int SCAN_CYC     = 5000,
   parameter int DEBOUNCE_CYC = 500000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] kp_col_n,
   output logic [3:0] kp_row_n,
   output logic       key_valid,
   output logic [3:0] key_code
);

   localparam int SW = $clog2(SCAN_CYC + 1);
   localparam int DW = $clog2(DEBOUNCE_CYC + 1);

   scan_state_t   state, state_nx;
   logic [3:0]    col_meta, col_s, col_snap;
   logic [1:0]    row_idx;
   logic [SW-1:0] scan_cnt;
   logic [DW-1:0] db_cnt;
   logic          settled, db_done;

   function automatic logic one_low(input logic [3:0] c_n);
      logic [3:0] c;
      c = ~c_n;
      return (c != 4'd0) && ((c & (c - 4'd1)) == 4'd0);
   endfunction

   function automatic logic [1:0] col_idx(input logic [3:0] c_n);
      logic [1:0] i;
      case (c_n)
         4'b1110: i = 2'd0;
         4'b1101: i = 2'd1;
         4'b1011: i = 2'd2;
         default: i = 2'd3;
      endcase
      return i;
   endfunction

   // col_s lags the pins by two cycles, so the first two cycles of each
   // row slot still show the previous row and must not be decoded.
   assign settled = (scan_cnt >= SW'(2));
   assign db_done = (db_cnt == DW'(DEBOUNCE_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= SCAN;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         SCAN:       if (settled && one_low(col_s)) state_nx = PRESS_DB;
         // A pattern that stays stable but is not a single key (released, or
         // several keys) abandons the press without an event.
         PRESS_DB:   if (col_s == col_snap && db_done)
                        state_nx = one_low(col_snap) ? EMIT : SCAN;
         EMIT:       state_nx = RELEASE_DB;
         RELEASE_DB: if (col_s == 4'hF && db_done) state_nx = SCAN;
         default:    state_nx = SCAN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_meta <= 4'hF;
         col_s    <= 4'hF;
         col_snap <= 4'hF;
         row_idx  <= 2'd0;
         scan_cnt <= '0;
         db_cnt   <= '0;
      end else begin
         col_meta <= kp_col_n;
         col_s    <= col_meta;
         case (state)
            SCAN: begin
               col_snap <= col_s;
               db_cnt   <= DW'(1);
               if (state_nx != SCAN) begin
                  scan_cnt <= '0;
               end else if (scan_cnt == SW'(SCAN_CYC - 1)) begin
                  scan_cnt <= '0;
                  row_idx  <= row_idx + 2'd1;
               end else begin
                  scan_cnt <= scan_cnt + SW'(1);
               end
            end
            PRESS_DB: begin
               if (col_s != col_snap) begin
                  col_snap <= col_s;
                  db_cnt   <= DW'(1);
               end else if (!db_done) begin
                  db_cnt <= db_cnt + DW'(1);
               end
            end
            EMIT: db_cnt <= '0;
            default: begin
               if (col_s != 4'hF)  db_cnt <= '0;
               else if (!db_done)  db_cnt <= db_cnt + DW'(1);
            end
         endcase
      end
   end

   always_comb begin
      kp_row_n  = ~(4'b0001 << row_idx);
      key_valid = (state == EMIT);
      key_code  = keymap(row_idx, col_idx(col_snap));
   end

endmodule

// File: rtl/calc_entry_ctrl.sv
// rtl/calc_entry_ctrl.sv - keypad calculator entry sequencer, ALU handshake and display source
//
// Purpose: turns key events into signed BCD operands A/B and an operator,
// requests the arithmetic unit, and selects what the HEX display shows.
// Optional build macro: CALC_CHAIN_EN (operator in SHOW continues from the result).
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   kp_col_n / kp_row_n              : keypad columns in / row drive out
//   alu_req, alu_op                  : request (held until alu_done), opcode
//   alu_a, alu_a_neg, alu_b, alu_b_neg : BCD operands and signs
//   alu_done, alu_res, alu_res_neg, alu_ovf : result handshake from the ALU
//   disp_bcd, disp_ndig, disp_neg, disp_blank : display stage value
module calc_entry_ctrl
   import calc_pkg::*;
#(
   parameter int SCAN_CYC     = 5000,
   parameter int DEBOUNCE_CYC = 500000,
   parameter int NDIG         = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  kp_col_n,
   output logic [3:0]  kp_row_n,
   output logic        alu_req,
   output logic [1:0]  alu_op,
   output logic [31:0] alu_a,
   output logic        alu_a_neg,
   output logic [31:0] alu_b,
   output logic        alu_b_neg,
   input  logic        alu_done,
   input  logic [31:0] alu_res,
   input  logic        alu_res_neg,
   input  logic        alu_ovf,
   output logic [31:0] disp_bcd,
   output logic [3:0]  disp_ndig,
   output logic        disp_neg,
   output logic        disp_blank
);

   entry_state_t state, state_nx;
   logic         key_valid;
   logic [3:0]   key_code;
   logic [3:0]   a_ndig, b_ndig, nd;
   logic [31:0]  res_bcd;
   logic         res_neg, res_blank, clear_pending;
   logic         is_digit, is_op, clr_now, do_clear, chain_ok, a_dig_ok, b_dig_ok;

   keypad_scan #(
      .SCAN_CYC     (SCAN_CYC),
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_scan (
      .clk       (clk),
      .rst_n     (rst_n),
      .kp_col_n  (kp_col_n),
      .kp_row_n  (kp_row_n),
      .key_valid (key_valid),
      .key_code  (key_code)
   );

   assign is_digit = (key_code <= KEY_9);
   assign is_op    = (key_code >= KEY_ADD) && (key_code <= KEY_DIV);
   // Leading zeros are absorbed and digits beyond NDIG are dropped.
   assign a_dig_ok = !(a_ndig == 4'd0 && key_code == KEY_0) && (a_ndig < 4'(NDIG));
   assign b_dig_ok = !(b_ndig == 4'd0 && key_code == KEY_0) && (b_ndig < 4'(NDIG));
   assign clr_now  = clear_pending || (key_valid && key_code == KEY_CLR);
   // C during CALC is deferred until the ALU answers so the handshake completes.
   assign do_clear = (state == CALC) ? (alu_done && clr_now)
                                     : (key_valid && key_code == KEY_CLR);

`ifdef CALC_CHAIN_EN
   assign chain_ok = ~res_blank;
`else
   assign chain_ok = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ENTER_A;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ENTER_A: if (key_valid && is_op && a_ndig != 4'd0) state_nx = OP_WAIT;
         OP_WAIT: if (key_valid && is_digit)                state_nx = ENTER_B;
         ENTER_B: if (key_valid && key_code == KEY_EQ)      state_nx = CALC;
         CALC:    if (alu_done) state_nx = clr_now ? ENTER_A : SHOW;
         SHOW: begin
            if (key_valid && is_digit)                  state_nx = ENTER_A;
            else if (key_valid && is_op && chain_ok)    state_nx = OP_WAIT;
         end
         default: state_nx = ENTER_A;
      endcase
      if (state != CALC && key_valid && key_code == KEY_CLR) state_nx = ENTER_A;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_req <= 1'b0;  alu_op <= OP_ADD;
         alu_a <= '0;      alu_a_neg <= 1'b0;  a_ndig <= 4'd0;
         alu_b <= '0;      alu_b_neg <= 1'b0;  b_ndig <= 4'd0;
         res_bcd <= '0;    res_neg <= 1'b0;    res_blank <= 1'b0;
         clear_pending <= 1'b0;
      end else if (do_clear) begin
         alu_req <= 1'b0;  alu_op <= OP_ADD;
         alu_a <= '0;      alu_a_neg <= 1'b0;  a_ndig <= 4'd0;
         alu_b <= '0;      alu_b_neg <= 1'b0;  b_ndig <= 4'd0;
         res_bcd <= '0;    res_neg <= 1'b0;    res_blank <= 1'b0;
         clear_pending <= 1'b0;
      end else if (state == CALC) begin
         if (key_valid && key_code == KEY_CLR) clear_pending <= 1'b1;
         if (alu_done) begin
            alu_req   <= 1'b0;
            res_bcd   <= alu_res;
            res_neg   <= alu_res_neg;
            res_blank <= alu_ovf;
         end
      end else if (key_valid) begin
         case (state)
            ENTER_A: begin
               if (is_digit) begin
                  if (a_dig_ok) begin
                     alu_a  <= {alu_a[27:0], key_code};
                     a_ndig <= a_ndig + 4'd1;
                  end
               end else if (key_code == KEY_SUB && a_ndig == 4'd0) begin
                  alu_a_neg <= ~alu_a_neg;
               end else if (is_op && a_ndig != 4'd0) begin
                  alu_op <= op_of_key(key_code);
               end
            end
            OP_WAIT: begin
               if (is_digit) begin
                  if (b_dig_ok) begin
                     alu_b  <= {alu_b[27:0], key_code};
                     b_ndig <= b_ndig + 4'd1;
                  end
               end else if (key_code == KEY_SUB) begin
                  alu_b_neg <= ~alu_b_neg;
               end else if (is_op) begin
                  alu_op <= op_of_key(key_code);
               end
            end
            ENTER_B: begin
               if (is_digit && b_dig_ok) begin
                  alu_b  <= {alu_b[27:0], key_code};
                  b_ndig <= b_ndig + 4'd1;
               end else if (key_code == KEY_EQ) begin
                  alu_req <= 1'b1;
               end
            end
            SHOW: begin
               if (is_digit) begin
                  alu_op <= OP_ADD;
                  alu_a  <= {28'd0, key_code};
                  a_ndig <= (key_code == KEY_0) ? 4'd0 : 4'd1;
                  alu_a_neg <= 1'b0;
                  alu_b <= '0;      alu_b_neg <= 1'b0;  b_ndig <= 4'd0;
                  res_bcd <= '0;    res_neg <= 1'b0;    res_blank <= 1'b0;
               end else if (is_op && chain_ok) begin
                  alu_op    <= op_of_key(key_code);
                  alu_a     <= res_bcd;
                  alu_a_neg <= res_neg;
                  a_ndig    <= bcd_ndig(res_bcd);
                  alu_b <= '0;      alu_b_neg <= 1'b0;  b_ndig <= 4'd0;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      disp_bcd   = alu_a;
      disp_neg   = alu_a_neg;
      disp_blank = 1'b0;
      nd         = a_ndig;
      case (state)
         ENTER_B, CALC: begin
            disp_bcd = alu_b;
            disp_neg = alu_b_neg;
            nd       = b_ndig;
         end
         SHOW: begin
            disp_bcd   = res_bcd;
            disp_neg   = res_neg;
            disp_blank = res_blank;
            nd         = bcd_ndig(res_bcd);
         end
         default: ;
      endcase
      disp_ndig = (nd == 4'd0) ? 4'd1 : nd;
   end

endmodule
